// File: rtl/svc_bench_mon.sv
`default_nettype none
// ============================================================================
// Module   : svc_bench_mon
// Brief    : Multi-channel benchmark monitor: per-region cycle/instret
//            counters, firmware exit code and a kickable watchdog behind a
//            small MMIO port. Define SVC_BENCH_MON_TRACE_EN for sim trace.
// Revision : 1.0 - initial release
// ============================================================================
module svc_bench_mon #(
    parameter int NUM_CH          = 4,
    parameter int CNT_WIDTH       = 48,
    parameter int WATCHDOG_CYCLES = 100_000_000,
    parameter int WDOG_WIDTH      = 32,
    parameter     PREFIX          = "bench"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        retire,
    output logic        done,
    output logic [7:0]  exit_code,
    output logic        wdog_expired,
    output logic        cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    localparam logic [1:0] c_op_start = 2'd1;
    localparam logic [1:0] c_op_stop  = 2'd2;
    localparam logic [1:0] c_op_clear = 2'd3;

    state_t               r_state     [NUM_CH];
    state_t               w_state_nxt [NUM_CH];
    logic [CNT_WIDTH-1:0] r_cyc       [NUM_CH];
    logic [CNT_WIDTH-1:0] r_ret       [NUM_CH];
    logic [NUM_CH-1:0]    w_clear;
    logic                 w_err;

    logic        r_done, r_wdog_expired, r_cmd_err, r_rd_valid;
    logic [7:0]  r_exit_code;
    logic [31:0] r_rd_data;
    logic [31:0] r_shadow;
    logic [4:0]  r_shadow_tag;
    logic        r_shadow_vld;

    logic       w_cmd, w_kick, w_exit, w_ch_ok, w_freeze, w_wd_expire;
    logic [1:0] w_op;
    logic [3:0] w_ch;

    assign w_cmd    = wr_en && (wr_addr == 2'd0);
    assign w_kick   = wr_en && (wr_addr == 2'd1);
    assign w_exit   = wr_en && (wr_addr == 2'd2);
    assign w_op     = wr_data[1:0];
    assign w_ch     = wr_data[7:4];
    assign w_ch_ok  = ({1'b0, w_ch} < 5'(NUM_CH));
    assign w_freeze = r_done | r_wdog_expired;

    always_comb begin
        w_err   = w_cmd && !w_ch_ok;
        w_clear = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_cmd && (w_ch == 4'(i))) begin
                case (w_op)
                    c_op_start: begin
                        if (r_state[i] == ST_RUNNING) w_err = 1'b1;
                        else                          w_state_nxt[i] = ST_RUNNING;
                    end
                    c_op_stop: begin
                        if (r_state[i] == ST_RUNNING) w_state_nxt[i] = ST_STOPPED;
                        else                          w_err = 1'b1;
                    end
                    c_op_clear: begin
                        w_state_nxt[i] = ST_IDLE;
                        w_clear[i]     = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_state[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // Counting keys off the pre-write state: a START edge is not counted, a STOP edge is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cyc[i] <= '0;
                r_ret[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_clear[i]) begin
                    r_cyc[i] <= '0;
                    r_ret[i] <= '0;
                end else if ((r_state[i] == ST_RUNNING) && !w_freeze) begin
                    if (r_cyc[i] != '1)            r_cyc[i] <= r_cyc[i] + 1'b1;
                    if (retire && (r_ret[i] != '1)) r_ret[i] <= r_ret[i] + 1'b1;
                end
            end
        end
    end

    generate
        if (WATCHDOG_CYCLES == 0) begin : g_wdog_off
            assign w_wd_expire = 1'b0;
        end else begin : g_wdog_on
            localparam logic [WDOG_WIDTH-1:0] c_wd_last = WDOG_WIDTH'(WATCHDOG_CYCLES - 1);
            logic [WDOG_WIDTH-1:0] r_wd_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)            r_wd_cnt <= '0;
                else if (w_kick)    r_wd_cnt <= '0;
                else if (!w_freeze) r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            assign w_wd_expire = !w_freeze && !w_kick && (r_wd_cnt == c_wd_last);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done         <= 1'b0;
            r_exit_code    <= '0;
            r_wdog_expired <= 1'b0;
            r_cmd_err      <= 1'b0;
        end else begin
            if (w_err)       r_cmd_err      <= 1'b1;
            if (w_wd_expire) r_wdog_expired <= 1'b1;
            if (w_exit) begin
                r_done      <= 1'b1;
                r_exit_code <= wr_data[7:0];
            end
        end
    end

    logic [3:0]  w_rd_ch;
    logic [1:0]  w_rd_sel;
    logic [4:0]  w_rd_tag;
    logic        w_rd_ch_ok, w_shadow_hit;
    logic [63:0] w_rd_cnt;

    assign w_rd_ch      = rd_addr[5:2];
    assign w_rd_sel     = rd_addr[1:0];
    assign w_rd_tag     = {w_rd_ch, w_rd_sel[1]};
    assign w_rd_ch_ok   = ({1'b0, w_rd_ch} < 5'(NUM_CH));
    assign w_shadow_hit = r_shadow_vld && (r_shadow_tag == w_rd_tag);

    always_comb begin
        w_rd_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_rd_ch == 4'(i)) w_rd_cnt = w_rd_sel[1] ? 64'(r_ret[i]) : 64'(r_cyc[i]);
        end
    end

    // The shadow is consumed by the first hi read that follows the lo read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_shadow     <= '0;
            r_shadow_tag <= '0;
            r_shadow_vld <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                if (!w_rd_sel[0]) begin
                    r_rd_data    <= w_rd_cnt[31:0];
                    r_shadow     <= w_rd_cnt[63:32];
                    r_shadow_tag <= w_rd_tag;
                    r_shadow_vld <= w_rd_ch_ok;
                end else begin
                    r_rd_data    <= w_shadow_hit ? r_shadow : w_rd_cnt[63:32];
                    r_shadow_vld <= 1'b0;
                end
            end
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign done         = r_done;
    assign exit_code    = r_exit_code;
    assign wdog_expired = r_wdog_expired;
    assign cmd_err      = r_cmd_err;

    logic w_unused;
    assign w_unused = ^{wr_data[31:8], wr_data[3:2], w_kick, PREFIX, 32'(WDOG_WIDTH)};

`ifdef SVC_BENCH_MON_TRACE_EN
    logic [63:0] w_tr_cyc, w_tr_ret;

    always_comb begin
        w_tr_cyc = '0;
        w_tr_ret = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == 4'(i)) begin
                w_tr_cyc = 64'(r_cyc[i]);
                w_tr_ret = 64'(r_ret[i]);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (w_cmd && w_ch_ok && (w_op != 2'd0))
                $display("%s @%0t ch%0d op=%0d cyc=%0d ret=%0d",
                         PREFIX, $time, w_ch, w_op, w_tr_cyc, w_tr_ret);
            if (w_exit && !r_done)
                $display("%s @%0t done code=%0d ch%0d cyc=%0d ret=%0d",
                         PREFIX, $time, wr_data[7:0], w_ch, w_tr_cyc, w_tr_ret);
            if (w_wd_expire)
                $display("%s @%0t watchdog expired ch%0d cyc=%0d ret=%0d",
                         PREFIX, $time, w_ch, w_tr_cyc, w_tr_ret);
        end
    end
`endif

endmodule
`default_nettype wire
